alu_mc: RTL and testbench

//   Parametrised multi-cycle ALU, successor to the combinational ALU in the npc core.

---
 rtl/alu_mc.sv | 155 +++++++++++++++
 tb/tb_alu_mc.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/alu_mc.sv
// Multi-cycle ALU: single-cycle logic/compare/shift ops, radix-2 iterative MUL/MULHU/DIVU/REMU.
// Latency 1 cycle (ops 0-11) or WIDTH+1 cycles (ops 12-15); in_ready only in IDLE, result held until out_ready.
module alu_mc #(
   parameter  int WIDTH = 32,
   localparam int SHW   = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       op,
   input  logic [WIDTH-1:0] r1,
   input  logic [WIDTH-1:0] r2,
   input  logic             flush,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             overflow
);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t             state_q;
   logic [1:0]         op_q;
   logic [WIDTH-1:0]   a_q;
   logic [WIDTH-1:0]   b_q;
   logic [2*WIDTH-1:0] prod_q;
   logic [SHW-1:0]     cnt_q;
   logic [WIDTH-1:0]   result_q;
   logic               overflow_q;

   logic [WIDTH-1:0]   alu_res;
   logic               alu_ovf;
   logic [WIDTH-1:0]   sum;
   logic [WIDTH-1:0]   diff;

   logic [WIDTH:0]     mul_sum;
   logic [WIDTH:0]     div_shift;
   logic [WIDTH:0]     div_diff;
   logic [2*WIDTH-1:0] step_d;
   logic [WIDTH-1:0]   fin_res;

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign result    = result_q;
   assign overflow  = overflow_q;

   assign sum  = r1 + r2;
   assign diff = r1 - r2;

   always_comb begin
      alu_res = '0;
      alu_ovf = 1'b0;
      case (op)
         4'd0: begin
            alu_res = sum;
            alu_ovf = (r1[WIDTH-1] == r2[WIDTH-1]) && (sum[WIDTH-1] != r1[WIDTH-1]);
         end
         4'd1: begin
            alu_res = diff;
            alu_ovf = (r1[WIDTH-1] != r2[WIDTH-1]) && (diff[WIDTH-1] != r1[WIDTH-1]);
         end
         4'd2:    alu_res = ~r1;
         4'd3:    alu_res = r1 & r2;
         4'd4:    alu_res = r1 | r2;
         4'd5:    alu_res = r1 ^ r2;
         4'd6:    alu_res = {{(WIDTH-1){1'b0}}, $signed(r1) < $signed(r2)};
         4'd7:    alu_res = {{(WIDTH-1){1'b0}}, r1 == r2};
         4'd8:    alu_res = {{(WIDTH-1){1'b0}}, r1 < r2};
         4'd9:    alu_res = r1 << r2[SHW-1:0];
         4'd10:   alu_res = r1 >> r2[SHW-1:0];
         4'd11:   alu_res = $unsigned($signed(r1) >>> r2[SHW-1:0]);
         default: alu_res = '0;
      endcase
   end

   // prod_q upper half: MUL accumulator / DIV partial remainder; lower half: multiplier / dividend->quotient
   always_comb begin
      mul_sum   = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, a_q} : '0);
      div_shift = {prod_q[2*WIDTH-1:WIDTH], prod_q[WIDTH-1]};
      div_diff  = div_shift - {1'b0, b_q};
      step_d    = '0;
      if (!op_q[1])
         step_d = {mul_sum, prod_q[WIDTH-1:1]};
      else if (!div_diff[WIDTH])
         step_d = {div_diff[WIDTH-1:0], prod_q[WIDTH-2:0], 1'b1};
      else
         step_d = {div_shift[WIDTH-1:0], prod_q[WIDTH-2:0], 1'b0};
   end

   // Divide by zero is resolved at the output so the iteration never needs a special case
   always_comb begin
      fin_res = '0;
      case (op_q)
         2'd0:    fin_res = step_d[WIDTH-1:0];
         2'd1:    fin_res = step_d[2*WIDTH-1:WIDTH];
         2'd2:    fin_res = (b_q == '0) ? '1  : step_d[WIDTH-1:0];
         default: fin_res = (b_q == '0) ? a_q : step_d[2*WIDTH-1:WIDTH];
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         op_q       <= '0;
         a_q        <= '0;
         b_q        <= '0;
         prod_q     <= '0;
         cnt_q      <= '0;
         result_q   <= '0;
         overflow_q <= 1'b0;
      end else if (flush) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         result_q   <= '0;
         overflow_q <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (in_valid) begin
                  op_q <= op[1:0];
                  a_q  <= r1;
                  b_q  <= r2;
                  if (op[3] && op[2]) begin
                     state_q    <= BUSY;
                     cnt_q      <= '0;
                     prod_q     <= op[1] ? {{WIDTH{1'b0}}, r1} : {{WIDTH{1'b0}}, r2};
                     overflow_q <= 1'b0;
                  end else begin
                     state_q    <= DONE;
                     result_q   <= alu_res;
                     overflow_q <= alu_ovf;
                  end
               end
            end
            BUSY: begin
               prod_q <= step_d;
               if (cnt_q == SHW'(WIDTH-1)) begin
                  cnt_q    <= '0;
                  result_q <= fin_res;
                  state_q  <= DONE;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            DONE: begin
               if (out_ready)
                  state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_mc.sv
// Directed-vector bench for alu_mc: ALU ops, iterative MUL/DIV, backpressure, reset and flush.
module tb_alu_mc;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [3:0]  op;
   logic [31:0] r1;
   logic [31:0] r2;
   logic        flush;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] result;
   logic        overflow;

   int n_checks = 0;
   int n_errors = 0;

   logic [31:0] res;
   logic        ovf;
   int          lat;

   alu_mc #(.WIDTH(32)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .op        (op),
      .r1        (r1),
      .r2        (r2),
      .flush     (flush),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .overflow  (overflow)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Issue one op, wait (bounded) for out_valid, then consume it.
   task automatic run_op(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] r, output logic v, output int l);
      @(negedge clk);
      in_valid = 1'b1;
      op       = o;
      r1       = a;
      r2       = b;
      @(posedge clk);
      #1 in_valid = 1'b0;
      l = 1;
      while (!out_valid && l < 100) begin
         @(posedge clk);
         #1 l++;
      end
      r = result;
      v = overflow;
      out_ready = 1'b1;
      @(posedge clk);
      #1 out_ready = 1'b0;
   endtask

   task automatic alu_vec(input string tag, input logic [3:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp);
      run_op(o, a, b, res, ovf, lat);
      check(tag, res, exp);
   endtask

   initial begin
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      op        = '0;
      r1        = '0;
      r2        = '0;
      flush     = 1'b0;
      out_ready = 1'b0;
      #12;
      check("reset_in_ready",  {31'd0, in_ready},  32'd1);
      check("reset_out_valid", {31'd0, out_valid}, 32'd0);
      check("reset_result",    result,             32'd0);
      check("reset_overflow",  {31'd0, overflow},  32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      run_op(4'd0, 32'h7FFF_FFFF, 32'h1, res, ovf, lat);
      check("add_res", res, 32'h8000_0000);
      check("add_ovf", {31'd0, ovf}, 32'd1);
      check("add_lat", lat, 32'd1);
      run_op(4'd1, 32'h8000_0000, 32'h1, res, ovf, lat);
      check("sub_res", res, 32'h7FFF_FFFF);
      check("sub_ovf", {31'd0, ovf}, 32'd1);
      run_op(4'd0, 32'd10, 32'd20, res, ovf, lat);
      check("add_noovf", {31'd0, ovf}, 32'd0);

      alu_vec("not",  4'd2,  32'h0F0F_0F0F, 32'h0,         32'hF0F0_F0F0);
      alu_vec("and",  4'd3,  32'hFF00_FF00, 32'h0FF0_0FF0, 32'h0F00_0F00);
      alu_vec("or",   4'd4,  32'hFF00_FF00, 32'h0FF0_0FF0, 32'hFFF0_FFF0);
      alu_vec("xor",  4'd5,  32'hFF00_FF00, 32'h0FF0_0FF0, 32'hF0F0_F0F0);
      alu_vec("slt",  4'd6,  32'hFFFF_FFFF, 32'h1,         32'd1);
      alu_vec("eq",   4'd7,  32'd5,         32'd5,         32'd1);
      alu_vec("neq",  4'd7,  32'd5,         32'd6,         32'd0);
      alu_vec("sltu", 4'd8,  32'hFFFF_FFFF, 32'h1,         32'd0);
      alu_vec("sll",  4'd9,  32'h1,         32'd31,        32'h8000_0000);
      alu_vec("srl",  4'd10, 32'h8000_0000, 32'd4,         32'h0800_0000);
      alu_vec("sra",  4'd11, 32'h8000_0000, 32'd4,         32'hF800_0000);

      run_op(4'd12, 32'hFFFF_FFFF, 32'hFFFF_FFFF, res, ovf, lat);
      check("mul_res", res, 32'h0000_0001);
      check("mul_lat", lat, 32'd33);
      check("mul_ovf", {31'd0, ovf}, 32'd0);
      alu_vec("mulhu", 4'd13, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
      alu_vec("mul2",  4'd12, 32'd12345,     32'd100,       32'd1234500);
      alu_vec("divu",  4'd14, 32'd100,       32'd7,         32'd14);
      alu_vec("remu",  4'd15, 32'd100,       32'd7,         32'd2);
      alu_vec("divu_big", 4'd14, 32'hFFFF_FFFF, 32'h1,      32'hFFFF_FFFF);
      alu_vec("remu_big", 4'd15, 32'hFFFF_FFFF, 32'h10,     32'hF);
      run_op(4'd14, 32'd5, 32'd0, res, ovf, lat);
      check("divu_zero", res, 32'hFFFF_FFFF);
      check("divu_zero_lat", lat, 32'd33);
      alu_vec("remu_zero", 4'd15, 32'd5, 32'd0, 32'd5);

      // Backpressure: result held, no accept while DONE, no accept on consume edge
      @(negedge clk);
      in_valid = 1'b1; op = 4'd0; r1 = 32'd3; r2 = 32'd4;
      @(posedge clk);
      #1 op = 4'd1; r1 = 32'd100; r2 = 32'd1;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         #1;
         check("bp_result", result, 32'd7);
         check("bp_valid",  {31'd0, out_valid}, 32'd1);
         check("bp_ready",  {31'd0, in_ready},  32'd0);
      end
      out_ready = 1'b1;
      @(posedge clk);
      #1 out_ready = 1'b0;
      check("bp_consume_ready", {31'd0, in_ready},  32'd1);
      check("bp_consume_valid", {31'd0, out_valid}, 32'd0);
      in_valid = 1'b0;

      // Async reset in the middle of a divide
      @(negedge clk);
      in_valid = 1'b1; op = 4'd14; r1 = 32'd1000; r2 = 32'd3;
      @(posedge clk);
      #1 in_valid = 1'b0;
      repeat (5) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("arst_ready",  {31'd0, in_ready},  32'd1);
      check("arst_valid",  {31'd0, out_valid}, 32'd0);
      check("arst_result", result, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // Flush in the middle of a multiply, after a prior result was left in the register
      alu_vec("pre_flush", 4'd0, 32'd8, 32'd9, 32'd17);
      @(negedge clk);
      in_valid = 1'b1; op = 4'd12; r1 = 32'd3; r2 = 32'd5;
      @(posedge clk);
      #1 in_valid = 1'b0;
      repeat (10) @(posedge clk);
      @(negedge clk);
      flush = 1'b1;
      @(posedge clk);
      #1 flush = 1'b0;
      check("flush_ready",  {31'd0, in_ready},  32'd1);
      check("flush_valid",  {31'd0, out_valid}, 32'd0);
      check("flush_result", result, 32'd0);
      lat = 0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk);
         #1 if (out_valid) lat++;
      end
      check("flush_no_late_valid", lat, 32'd0);
      run_op(4'd0, 32'd2, 32'd3, res, ovf, lat);
      check("post_flush_add", res, 32'd5);
      check("post_flush_lat", lat, 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
